// File: rtl/riscv_trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_trace_pkg
//  Description : Shared constants, FSM state type and dump-entry record for
//                the writeback tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_trace_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int REG_AW    = $clog2(NREGS_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DUMP = 2'd1,
        ST_DONE = 2'd2
    } trace_state_t;

    typedef struct packed {
        logic [REG_AW-1:0]   idx;
        logic [XLEN_DEF-1:0] data;
    } dump_entry_t;

endpackage
`default_nettype wire

// File: rtl/riscv_wb_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_wb_tracker_if
//  Description : Writeback/dump bundle between pipeline, tracker and sink.
//  Revision    : 1.0 - initial release
// ============================================================================
interface riscv_wb_tracker_if
    import riscv_trace_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int COUNT_W = 16
);

    logic              wb_e;
    logic [REG_AW-1:0] wb_a;
    logic [XLEN-1:0]   wb_d;
    logic [XLEN-1:0]   pc_in;
    logic              dump;
    logic              out_ready;
    logic              out_valid;
    logic [REG_AW-1:0] out_idx;
    logic [XLEN-1:0]   out_data;
    logic [XLEN-1:0]   out_pc;
    logic              busy;
    logic              done;
    logic [COUNT_W-1:0] wr_count;

    modport master (
        output wb_e, wb_a, wb_d, pc_in, dump, out_ready,
        input  out_valid, out_idx, out_data, out_pc, busy, done, wr_count
    );

    modport slave (
        input  wb_e, wb_a, wb_d, pc_in, dump, out_ready,
        output out_valid, out_idx, out_data, out_pc, busy, done, wr_count
    );

endinterface
`default_nettype wire

// File: rtl/riscv_wb_tracker_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_shadow_regfile
//  Description : Shadow register file, one write port, forwarded read port.
//                RISCV_WB_TRACKER_SKIP_ZERO_EN adds a forwarded nonzero map.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_shadow_regfile
    import riscv_trace_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = REG_AW
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            we_i,
    input  wire logic [AW-1:0]   wa_i,
    input  wire logic [XLEN-1:0] wd_i,
    input  wire logic [AW-1:0]   ra_i,
    output      logic [XLEN-1:0] rd_o
`ifdef RISCV_WB_TRACKER_SKIP_ZERO_EN
    ,
    output      logic [NREGS-1:0] nz_o
`endif
);

    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [XLEN-1:0] fwd    [NREGS];

    // x0 has no storage at all, so it reads zero by construction.
    for (genvar i = 1; i < NREGS; i++) begin : g_reg
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                regs_q[i] <= '0;
            end else if (we_i && (wa_i == AW'(i))) begin
                regs_q[i] <= wd_i;
            end
        end
    end

    always_comb begin
        fwd[0] = '0;
        for (int i = 1; i < NREGS; i++) begin
            fwd[i] = (we_i && (wa_i == AW'(i))) ? wd_i : regs_q[i];
        end
    end

    assign rd_o = fwd[ra_i];

`ifdef RISCV_WB_TRACKER_SKIP_ZERO_EN
    always_comb begin
        nz_o = '0;
        for (int i = 0; i < NREGS; i++) begin
            nz_o[i] = |fwd[i];
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/riscv_wb_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_wb_tracker
//  Description : Shadows pipeline writebacks, counts commits and streams a
//                register snapshot on a dump request.
//                RISCV_WB_TRACKER_SKIP_ZERO_EN skips zero-valued entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_wb_tracker
    import riscv_trace_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREGS   = NREGS_DEF,
    parameter int COUNT_W = 16
) (
    input wire logic          clk,
    input wire logic          reset,
    riscv_wb_tracker_if.slave bus
);

    localparam int AW = REG_AW;

    trace_state_t       state_q;
    dump_entry_t        entry_q;
    logic               dump_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;
    logic [XLEN-1:0]    pc_q;
    logic [COUNT_W-1:0] cnt_q;

    logic               rise;
    logic               commit;
    logic [AW-1:0]      idx_d;
    logic               found_d;
    logic [XLEN-1:0]    data_d;

    assign rise   = bus.dump && !dump_q;
    assign commit = bus.wb_e && (bus.wb_a != '0);

`ifdef RISCV_WB_TRACKER_SKIP_ZERO_EN
    logic [NREGS-1:0] nz;

    // Descending scan so the last hit is the lowest qualifying index.
    always_comb begin
        found_d = 1'b0;
        idx_d   = '0;
        for (int j = NREGS - 1; j > 0; j--) begin
            if (nz[j] && ((state_q == ST_IDLE) || (AW'(j) > entry_q.idx))) begin
                found_d = 1'b1;
                idx_d   = AW'(j);
            end
        end
    end
`else
    always_comb begin
        if (state_q == ST_IDLE) begin
            idx_d   = '0;
            found_d = 1'b1;
        end else begin
            idx_d   = entry_q.idx + AW'(1);
            found_d = (entry_q.idx != AW'(NREGS - 1));
        end
    end
`endif

    riscv_shadow_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_regs (
        .clk   (clk),
        .reset (reset),
        .we_i  (commit),
        .wa_i  (bus.wb_a),
        .wd_i  (bus.wb_d),
        .ra_i  (idx_d),
        .rd_o  (data_d)
`ifdef RISCV_WB_TRACKER_SKIP_ZERO_EN
        ,
        .nz_o  (nz)
`endif
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            entry_q <= '0;
            dump_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            dump_q <= bus.dump;
            if (commit && (cnt_q != '1)) begin
                cnt_q <= cnt_q + COUNT_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        pc_q <= bus.pc_in;
                        if (found_d) begin
                            state_q      <= ST_DUMP;
                            busy_q       <= 1'b1;
                            valid_q      <= 1'b1;
                            entry_q.idx  <= idx_d;
                            entry_q.data <= data_d;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DUMP: begin
                    // Entry is a snapshot: it only changes on a transfer.
                    if (valid_q && bus.out_ready) begin
                        if (found_d) begin
                            entry_q.idx  <= idx_d;
                            entry_q.data <= data_d;
                        end else begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!bus.dump) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_idx   = entry_q.idx;
    assign bus.out_data  = entry_q.data;
    assign bus.out_pc    = pc_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.wr_count  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_wb_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_wb_tracker
//  Description : Directed self-checking bench for riscv_wb_tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_wb_tracker;
    import riscv_trace_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    riscv_wb_tracker_if #(.XLEN(32), .COUNT_W(16)) bus ();

    riscv_wb_tracker #(
        .XLEN    (32),
        .NREGS   (32),
        .COUNT_W (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    int          ref_cnt;
    logic [31:0] ref_regs [32];
    logic [31:0] exp_vals [32];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input int a, input logic [31:0] d);
        bus.wb_e = 1'b1;
        bus.wb_a = 5'(a);
        bus.wb_d = d;
        tick();
        bus.wb_e = 1'b0;
        if (a != 0) begin
            ref_regs[a] = d;
            ref_cnt++;
        end
    endtask

    function automatic int next_exp(input int prev);
`ifdef RISCV_WB_TRACKER_SKIP_ZERO_EN
        for (int j = prev + 1; j < 32; j++) begin
            if (j != 0 && exp_vals[j] != 0) return j;
        end
        return 32;
`else
        return prev + 1;
`endif
    endfunction

    function automatic int exp_count();
`ifdef RISCV_WB_TRACKER_SKIP_ZERO_EN
        int n = 0;
        for (int j = 1; j < 32; j++) if (exp_vals[j] != 0) n++;
        return n;
`else
        return 32;
`endif
    endfunction

    // mode 0: ready high; 1: ready 1-0-0-1; 2: stall on x5 and write meanwhile;
    // 3: ready high, dump re-pulsed mid-dump; 4: stop once idx 10 is presented.
    task automatic run_dump(input int mode, output int n_xfer, output int n_cyc);
        int          cyc;
        int          stall_n;
        int          exp_idx;
        bit          prev_stall;
        bit          rdy;
        logic [4:0]  p_idx;
        logic [31:0] p_data;
        logic [31:0] e_data;
        cyc = 0; stall_n = 0; prev_stall = 1'b0; n_xfer = 0;
        p_idx = '0; p_data = '0;
        exp_idx = next_exp(-1);
        while (!bus.done && cyc < 400 &&
               !(mode == 4 && bus.out_valid && bus.out_idx == 5'd10)) begin
            bus.wb_e = 1'b0;
            if (prev_stall) begin
                check_eq("hold_valid", bus.out_valid, 1);
                check_eq("hold_idx", bus.out_idx, p_idx);
                check_eq("hold_data", bus.out_data, p_data);
            end
            rdy = 1'b1;
            if (mode == 1) rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (mode == 2 && bus.out_valid && bus.out_idx == 5'd5) begin
                bus.wb_e = 1'b1;
                if (stall_n == 0) begin
                    rdy = 1'b0;
                    bus.wb_a = 5'd5;  bus.wb_d = 32'hAAAA_0000;
                    ref_regs[5] = 32'hAAAA_0000;
                end else if (stall_n == 1) begin
                    rdy = 1'b0;
                    bus.wb_a = 5'd20; bus.wb_d = 32'h0000_0077;
                    ref_regs[20] = 32'h77; exp_vals[20] = 32'h77;
                end else if (stall_n == 2) begin
                    rdy = 1'b0;
                    bus.wb_e = 1'b0;
                end else begin
                    // Lands on the same edge that presents x6.
                    bus.wb_a = 5'd6;  bus.wb_d = 32'h6666_0000;
                    ref_regs[6] = 32'h6666_0000; exp_vals[6] = 32'h6666_0000;
                end
                if (bus.wb_e) ref_cnt++;
                stall_n++;
            end
            if (mode == 3 && cyc == 5) bus.dump = 1'b0;
            if (mode == 3 && cyc == 6) bus.dump = 1'b1;
            bus.out_ready = rdy;
            if (bus.out_valid && rdy) begin
                e_data = (exp_idx < 32) ? exp_vals[exp_idx] : 32'h0;
                check_eq("entry_idx", bus.out_idx, exp_idx);
                check_eq("entry_data", bus.out_data, e_data);
                exp_idx = next_exp(exp_idx);
                n_xfer++;
            end
            prev_stall = bus.out_valid && !rdy;
            p_idx  = bus.out_idx;
            p_data = bus.out_data;
            tick();
            cyc++;
        end
        bus.wb_e = 1'b0;
        bus.out_ready = 1'b1;
        if (mode != 4) begin
            check_eq("dump_done", bus.done, 1);
            check_eq("done_no_valid", bus.out_valid, 0);
        end
        n_cyc = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted, required self-termination");
        $fatal(1);
    end

    initial begin
        int nx;
        int nc;
        reset = 1'b0;
        bus.wb_e = 1'b0; bus.wb_a = '0; bus.wb_d = '0;
        bus.pc_in = '0; bus.dump = 1'b0; bus.out_ready = 1'b1;
        ref_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            ref_regs[i] = '0;
            exp_vals[i] = '0;
        end
        tick(); tick();

        check_eq("rst_valid", bus.out_valid, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_count", bus.wr_count, 0);
        check_eq("rst_idx", bus.out_idx, 0);
        check_eq("rst_data", bus.out_data, 0);
        check_eq("rst_pc", bus.out_pc, 0);
        reset = 1'b1;
        tick();

        // Basic dump
        wb_write(1, 32'hDEADBEEF);
        wb_write(2, 32'h12345678);
        wb_write(3, 32'hFEDCBA98);
        wb_write(0, 32'h00000005);
        check_eq("count_basic", bus.wr_count, 3);
        for (int i = 0; i < 32; i++) exp_vals[i] = ref_regs[i];
        bus.pc_in = 32'h8000_0040;
        bus.dump = 1'b1;
        tick();
        bus.dump = 1'b0;
        bus.pc_in = 32'h1111_2222;
        check_eq("start_valid", bus.out_valid, 1);
        check_eq("start_busy", bus.busy, 1);
        check_eq("start_idx", bus.out_idx, next_exp(-1));
        check_eq("start_pc", bus.out_pc, 32'h8000_0040);
        run_dump(0, nx, nc);
        check_eq("xfers_basic", nx, exp_count());
`ifndef RISCV_WB_TRACKER_SKIP_ZERO_EN
        // done appears in cycle N+33, i.e. 32 edges after the trigger edge.
        check_eq("done_latency", nc, 32);
`endif
        check_eq("pc_held", bus.out_pc, 32'h8000_0040);
        tick();
        check_eq("done_release", bus.done, 0);

        // Backpressure
        for (int i = 0; i < 32; i++) exp_vals[i] = ref_regs[i];
        bus.dump = 1'b1; tick(); bus.dump = 1'b0;
        run_dump(1, nx, nc);
        check_eq("xfers_bp", nx, exp_count());
        tick();

        // Writes during dump
        wb_write(5, 32'h0000_0055);
        wb_write(6, 32'h0000_0066);
        for (int i = 0; i < 32; i++) exp_vals[i] = ref_regs[i];
        bus.dump = 1'b1; tick(); bus.dump = 1'b0;
        run_dump(2, nx, nc);
        check_eq("xfers_wr", nx, exp_count());
        tick();
        check_eq("count_wr", bus.wr_count, ref_cnt);

        // Dump held high, re-pulsed mid-dump
        for (int i = 0; i < 32; i++) exp_vals[i] = ref_regs[i];
        bus.dump = 1'b1; tick();
        run_dump(3, nx, nc);
        check_eq("xfers_edge", nx, exp_count());
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("done_hold", bus.done, 1);
            check_eq("done_hold_valid", bus.out_valid, 0);
        end
        bus.dump = 1'b0; tick();
        check_eq("idle_done", bus.done, 0);
        check_eq("idle_busy", bus.busy, 0);
        bus.dump = 1'b1; tick(); bus.dump = 1'b0;
        check_eq("redump_valid", bus.out_valid, 1);
        run_dump(0, nx, nc);
        check_eq("xfers_redump", nx, exp_count());
        tick();

        // Reset mid-dump
        for (int i = 0; i < 32; i++) exp_vals[i] = ref_regs[i];
        bus.dump = 1'b1; tick(); bus.dump = 1'b0;
        run_dump(4, nx, nc);
`ifndef RISCV_WB_TRACKER_SKIP_ZERO_EN
        check_eq("abort_idx", bus.out_idx, 10);
`endif
        #2;
        reset = 1'b0;
        #1;
        check_eq("abort_valid", bus.out_valid, 0);
        check_eq("abort_count", bus.wr_count, 0);
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_idx0", bus.out_idx, 0);
        check_eq("abort_data0", bus.out_data, 0);
        tick();
        reset = 1'b1;
        ref_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            ref_regs[i] = '0;
            exp_vals[i] = '0;
        end
        tick();
        bus.dump = 1'b1; tick(); bus.dump = 1'b0;
`ifdef RISCV_WB_TRACKER_SKIP_ZERO_EN
        check_eq("zero_done", bus.done, 1);
        check_eq("zero_valid", bus.out_valid, 0);
`endif
        run_dump(0, nx, nc);
        check_eq("xfers_zero", nx, exp_count());
        tick();

`ifdef RISCV_WB_TRACKER_SKIP_ZERO_EN
        wb_write(7, 32'd4);
        wb_write(31, 32'd1);
        for (int i = 0; i < 32; i++) exp_vals[i] = ref_regs[i];
        bus.dump = 1'b1; tick(); bus.dump = 1'b0;
        check_eq("skip_first", bus.out_idx, 7);
        run_dump(0, nx, nc);
        check_eq("xfers_skip", nx, 2);
        check_eq("count_skip", bus.wr_count, 2);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
